axi_lat_mem_slave: RTL and testbench
====================================

Name: axi_lat_mem_slave

Overview:
Parametrised AXI-lite memory slave used as the simulation backing store behind the cache's AXI master. It is the successor to the fixed-latency single-FSM memory model. Read and write channels run as independent FSMs, with configurable data width, memory depth, per-channel latency and base address. Out-of-range accesses return SLVERR, and AW/W may arrive in either order.

Parameters:
DATA_W, 128, data bus width in bits; power of 2, 64..512
ADDR_W, 64, address width
MEM_WORDS, 1024, internal memory depth in DATA_W-bit words; power of 2
BASE_ADDR, 64'h8000_0000, byte address of word 0
RD_LAT, 3, clock edges from AR handshake to rvalid; must be >= 1
WR_LAT, 3, clock edges from AW+W both captured to bvalid; must be >= 1

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
axi_readAddr_valid  in  1  AR valid
axi_readAddr_ready  out  1  AR ready
axi_readAddr_bits_addr  in  ADDR_W  read byte address
axi_readAddr_bits_prot  in  3  ignored
axi_readData_valid  out  1  R valid
axi_readData_ready  in  1  R ready
axi_readData_bits_data  out  DATA_W  read data
axi_readData_bits_resp  out  2  00 OKAY, 10 SLVERR
axi_writeAddr_valid  in  1  AW valid
axi_writeAddr_ready  out  1  AW ready
axi_writeAddr_bits_addr  in  ADDR_W  write byte address
axi_writeAddr_bits_prot  in  3  ignored
axi_writeData_valid  in  1  W valid
axi_writeData_ready  out  1  W ready
axi_writeData_bits_data  in  DATA_W  write data
axi_writeData_bits_strb  in  DATA_W/8  byte strobes
axi_writeResp_valid  out  1  B valid
axi_writeResp_ready  in  1  B ready
axi_writeResp_bits  out  2  00 OKAY, 10 SLVERR

Behaviour:
- Clock is clk; reset rst is synchronous, active-high. All state updates on posedge clk.
- Reset values: both FSMs idle; arready=1, awready=1, wready=1; rvalid=0, bvalid=0; rdata=0, rresp=0, bresp=0; latency counters 0. Memory contents are not cleared.
- Word index: idx = (addr - BASE_ADDR) >> log2(DATA_W/8). Low address bits are ignored (aligned word access).
- In range means BASE_ADDR <= addr < BASE_ADDR + MEM_WORDS*DATA_W/8. Otherwise the access is an error.
- Read FSM R_IDLE -> R_WAIT -> R_RESP:
  - R_IDLE: arready=1. On arvalid, latch idx and the error flag, load counter with RD_LAT-1, go to R_WAIT.
  - R_WAIT: arready=0. Decrement the counter each cycle. At 0, capture mem[idx] (or 0 with resp=10 on error) and go to R_RESP.
  - R_RESP: rvalid=1. Data and resp are held stable until rready. On rready, go to R_IDLE; rvalid drops the next cycle.
  - Net timing: rvalid is high RD_LAT edges after the AR handshake edge. No back-to-back AR is accepted in the R_RESP handshake cycle.
- Write FSM W_IDLE -> W_WAIT -> W_RESP:
  - W_IDLE: awready=1 until AW is captured, then 0. wready=1 until W is captured, then 0. AW and W may arrive in the same cycle or either order, with any gap.
  - When both are captured (including the capture edge itself), load counter with WR_LAT-1 and go to W_WAIT.
  - W_WAIT: at counter 0, commit mem[idx] byte-wise where strb=1. Commits are suppressed on error or all-zero strb. Go to W_RESP.
  - W_RESP: bvalid=1, bresp held until bready. On bready, go to W_IDLE.
- Simultaneous write commit and read capture to the same idx on one edge: the read captures the post-write (merged) data.
- Read and write FSMs are fully independent. Any mix of concurrent read and write transactions is legal.
- Reset mid-transaction: in-flight transactions are dropped with no response. A write commit scheduled on the reset edge is not performed.
- Valid signals never depend combinationally on ready.

Test Plan:
- DATA_W=128, RD_LAT=3: after reset, AR 0x8000_0010 -> arready=1 in the reset-release cycle; rvalid rises exactly 3 edges after the handshake; data=mem[1]; resp=00.
- AW 0x8000_0020 at cycle 5, W data=0x..FF_EEDD, strb=16'h0003 at cycle 9 -> bvalid 3 edges after cycle 9. Read back returns only bytes 0-1 updated; the other 14 bytes are unchanged.
- AW and W in the same cycle with rready/bready held 0 for 10 cycles -> rvalid/bvalid and their data remain stable and hold for all 10 cycles; arready stays 0.
- AR 0x7FFF_FFF0 and AW 0x8000_0000+MEM_WORDS*16 -> rresp=10 with data 0; bresp=10; memory unchanged.
- RD_LAT=WR_LAT=2: AR and AW+W to the same address in the same cycle -> the read returns the newly written bytes.
- Assert rst during W_WAIT -> no bvalid, memory unchanged, awready=wready=1 in the next cycle.

Source files
------------

// File: rtl/axi_lat_mem_slave_if.sv
// axi_lat_mem_slave_if: AXI-lite AR/R/AW/W/B bundle; master drives requests, W data and readies for R/B, slave answers
interface axi_lat_mem_slave_if #(parameter int DATA_W = 128, parameter int ADDR_W = 64);
  logic                  axi_readAddr_valid;
  logic                  axi_readAddr_ready;
  logic [ADDR_W-1:0]     axi_readAddr_bits_addr;
  logic [2:0]            axi_readAddr_bits_prot;
  logic                  axi_readData_valid;
  logic                  axi_readData_ready;
  logic [DATA_W-1:0]     axi_readData_bits_data;
  logic [1:0]            axi_readData_bits_resp;
  logic                  axi_writeAddr_valid;
  logic                  axi_writeAddr_ready;
  logic [ADDR_W-1:0]     axi_writeAddr_bits_addr;
  logic [2:0]            axi_writeAddr_bits_prot;
  logic                  axi_writeData_valid;
  logic                  axi_writeData_ready;
  logic [DATA_W-1:0]     axi_writeData_bits_data;
  logic [DATA_W/8-1:0]   axi_writeData_bits_strb;
  logic                  axi_writeResp_valid;
  logic                  axi_writeResp_ready;
  logic [1:0]            axi_writeResp_bits;
  modport master (
    output axi_readAddr_valid, axi_readAddr_bits_addr, axi_readAddr_bits_prot, axi_readData_ready,
           axi_writeAddr_valid, axi_writeAddr_bits_addr, axi_writeAddr_bits_prot,
           axi_writeData_valid, axi_writeData_bits_data, axi_writeData_bits_strb, axi_writeResp_ready,
    input  axi_readAddr_ready, axi_readData_valid, axi_readData_bits_data, axi_readData_bits_resp,
           axi_writeAddr_ready, axi_writeData_ready, axi_writeResp_valid, axi_writeResp_bits
  );
  modport slave (
    input  axi_readAddr_valid, axi_readAddr_bits_addr, axi_readAddr_bits_prot, axi_readData_ready,
           axi_writeAddr_valid, axi_writeAddr_bits_addr, axi_writeAddr_bits_prot,
           axi_writeData_valid, axi_writeData_bits_data, axi_writeData_bits_strb, axi_writeResp_ready,
    output axi_readAddr_ready, axi_readData_valid, axi_readData_bits_data, axi_readData_bits_resp,
           axi_writeAddr_ready, axi_writeData_ready, axi_writeResp_valid, axi_writeResp_bits
  );
endinterface

// File: rtl/axi_lat_mem_slave.sv
// axi_lat_mem_slave: latency-configurable AXI-lite memory slave (clk, rst, bus: slave modport of axi_lat_mem_slave_if)
module axi_lat_mem_slave #(
  parameter int                DATA_W    = 128,
  parameter int                ADDR_W    = 64,
  parameter int                MEM_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'h8000_0000,
  parameter int                RD_LAT    = 3,
  parameter int                WR_LAT    = 3
) (
  input logic clk,
  input logic rst,
  axi_lat_mem_slave_if.slave bus
);
  localparam int NB = DATA_W / 8;
  localparam int OB = $clog2(NB);
  localparam int IW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(RD_LAT > WR_LAT ? RD_LAT : WR_LAT) + 1;
  localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(MEM_WORDS * NB);
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_st_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_st_t;
  logic [DATA_W-1:0] mem [MEM_WORDS];
  r_st_t             r_st_q;
  logic [CW-1:0]     r_cnt_q;
  logic [IW-1:0]     r_idx_q;
  logic              r_err_q, arready_q, rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;
  w_st_t             w_st_q;
  logic [CW-1:0]     w_cnt_q;
  logic [IW-1:0]     w_idx_q;
  logic              w_err_q, aw_got_q, w_got_q, awready_q, wready_q, bvalid_q;
  logic [DATA_W-1:0] wdata_q, w_merged;
  logic [NB-1:0]     wstrb_q;
  logic [1:0]        bresp_q;
  logic [ADDR_W-1:0] ar_off, aw_off;
  logic              aw_hs, w_hs, w_commit, unused_prot;
  // Unsigned subtraction wraps addresses below BASE_ADDR to huge offsets, so one compare covers both bounds
  assign ar_off      = bus.axi_readAddr_bits_addr - BASE_ADDR;
  assign aw_off      = bus.axi_writeAddr_bits_addr - BASE_ADDR;
  assign aw_hs       = bus.axi_writeAddr_valid && awready_q;
  assign w_hs        = bus.axi_writeData_valid && wready_q;
  assign w_commit    = w_st_q == W_WAIT && w_cnt_q == '0 && !w_err_q && |wstrb_q;
  assign unused_prot = ^{bus.axi_readAddr_bits_prot, bus.axi_writeAddr_bits_prot};
  always_comb begin
    w_merged = mem[w_idx_q];
    for (int b = 0; b < NB; b++) w_merged[8*b+:8] = wstrb_q[b] ? wdata_q[8*b+:8] : w_merged[8*b+:8];
  end
  always_ff @(posedge clk) if (w_commit && !rst) mem[w_idx_q] <= w_merged;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st_q    <= R_IDLE;
      r_cnt_q   <= '0;
      r_idx_q   <= '0;
      r_err_q   <= 1'b0;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      case (r_st_q)
        R_IDLE: if (bus.axi_readAddr_valid) begin
          r_idx_q   <= ar_off[OB+:IW];
          r_err_q   <= ar_off >= SPAN;
          r_cnt_q   <= CW'(RD_LAT - 1);
          arready_q <= 1'b0;
          r_st_q    <= R_WAIT;
        end
        R_WAIT: if (r_cnt_q == '0) begin
          // A commit to the same word on this edge is forwarded so the read sees merged data
          rdata_q  <= r_err_q ? '0 : (w_commit && w_idx_q == r_idx_q) ? w_merged : mem[r_idx_q];
          rresp_q  <= r_err_q ? 2'b10 : 2'b00;
          rvalid_q <= 1'b1;
          r_st_q   <= R_RESP;
        end else r_cnt_q <= r_cnt_q - 1'b1;
        R_RESP: if (bus.axi_readData_ready) begin
          rvalid_q  <= 1'b0;
          arready_q <= 1'b1;
          r_st_q    <= R_IDLE;
        end
        default: r_st_q <= R_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      w_st_q    <= W_IDLE;
      w_cnt_q   <= '0;
      w_idx_q   <= '0;
      w_err_q   <= 1'b0;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= 2'b00;
    end else begin
      case (w_st_q)
        W_IDLE: begin
          if (aw_hs) begin
            w_idx_q   <= aw_off[OB+:IW];
            w_err_q   <= aw_off >= SPAN;
            awready_q <= 1'b0;
            aw_got_q  <= 1'b1;
          end
          if (w_hs) begin
            wdata_q  <= bus.axi_writeData_bits_data;
            wstrb_q  <= bus.axi_writeData_bits_strb;
            wready_q <= 1'b0;
            w_got_q  <= 1'b1;
          end
          if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) begin
            w_cnt_q <= CW'(WR_LAT - 1);
            w_st_q  <= W_WAIT;
          end
        end
        W_WAIT: if (w_cnt_q == '0) begin
          bresp_q  <= w_err_q ? 2'b10 : 2'b00;
          bvalid_q <= 1'b1;
          w_st_q   <= W_RESP;
        end else w_cnt_q <= w_cnt_q - 1'b1;
        W_RESP: if (bus.axi_writeResp_ready) begin
          bvalid_q  <= 1'b0;
          awready_q <= 1'b1;
          wready_q  <= 1'b1;
          aw_got_q  <= 1'b0;
          w_got_q   <= 1'b0;
          w_st_q    <= W_IDLE;
        end
        default: w_st_q <= W_IDLE;
      endcase
    end
  end
  assign bus.axi_readAddr_ready     = arready_q;
  assign bus.axi_readData_valid     = rvalid_q;
  assign bus.axi_readData_bits_data = rdata_q;
  assign bus.axi_readData_bits_resp = rresp_q;
  assign bus.axi_writeAddr_ready    = awready_q;
  assign bus.axi_writeData_ready    = wready_q;
  assign bus.axi_writeResp_valid    = bvalid_q;
  assign bus.axi_writeResp_bits     = bresp_q;
endmodule

// File: tb/tb_axi_lat_mem_slave.sv
// tb_axi_lat_mem_slave: directed table-driven bench for axi_lat_mem_slave plus multi-cycle corner sequences
module tb_axi_lat_mem_slave;
  localparam logic [127:0] D0  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] D1  = 128'h01010101_02020202_03030303_04040404;
  localparam logic [127:0] D2  = 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5;
  localparam logic [127:0] D3  = 128'h33333333_33333333_33333333_33333333;
  localparam logic [127:0] DL  = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [127:0] D5A = {16{8'h5A}};
  localparam logic [127:0] M0  = 128'h5A112233_44556677_8899AABB_CCDDEE5A;
  localparam logic [127:0] DB  = {16{8'h11}};
  localparam logic [127:0] DC  = {16{8'h22}};
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  axi_lat_mem_slave_if #(.DATA_W(128), .ADDR_W(64)) bus ();
  axi_lat_mem_slave_if #(.DATA_W(128), .ADDR_W(64)) bus2 ();
  axi_lat_mem_slave #(.DATA_W(128), .ADDR_W(64), .MEM_WORDS(1024), .BASE_ADDR(64'h8000_0000),
    .RD_LAT(3), .WR_LAT(3)) u_dut (.clk(clk), .rst(rst), .bus(bus));
  axi_lat_mem_slave #(.DATA_W(128), .ADDR_W(64), .MEM_WORDS(1024), .BASE_ADDR(64'h8000_0000),
    .RD_LAT(2), .WR_LAT(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));
  typedef struct {
    bit           wr;
    logic [63:0]  addr;
    logic [127:0] data;
    logic [15:0]  strb;
    logic [1:0]   resp;
  } vec_t;
  vec_t vecs [16];
  int n_tests = 0;
  int n_fail = 0;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_write(input logic [63:0] a, input logic [127:0] d, input logic [15:0] s, input logic [1:0] r);
    int n;
    chk("aw/w ready idle", {bus.axi_writeAddr_ready, bus.axi_writeData_ready}, 2'b11);
    bus.axi_writeAddr_valid = 1'b1;
    bus.axi_writeAddr_bits_addr = a;
    bus.axi_writeData_valid = 1'b1;
    bus.axi_writeData_bits_data = d;
    bus.axi_writeData_bits_strb = s;
    step();
    bus.axi_writeAddr_valid = 1'b0;
    bus.axi_writeData_valid = 1'b0;
    n = 0;
    while (!bus.axi_writeResp_valid && n < 20) begin step(); n++; end
    chk("write latency", n, 3);
    chk("bresp", bus.axi_writeResp_bits, r);
    bus.axi_writeResp_ready = 1'b1;
    step();
    bus.axi_writeResp_ready = 1'b0;
    chk("bvalid drop", bus.axi_writeResp_valid, 1'b0);
  endtask
  task automatic do_read(input logic [63:0] a, input logic [127:0] d, input logic [1:0] r);
    int n;
    chk("arready idle", bus.axi_readAddr_ready, 1'b1);
    bus.axi_readAddr_valid = 1'b1;
    bus.axi_readAddr_bits_addr = a;
    step();
    bus.axi_readAddr_valid = 1'b0;
    chk("arready busy", bus.axi_readAddr_ready, 1'b0);
    n = 0;
    while (!bus.axi_readData_valid && n < 20) begin step(); n++; end
    chk("read latency", n, 3);
    chk("rdata", bus.axi_readData_bits_data, d);
    chk("rresp", bus.axi_readData_bits_resp, r);
    bus.axi_readData_ready = 1'b1;
    step();
    bus.axi_readData_ready = 1'b0;
    chk("rvalid drop/arready back", {bus.axi_readData_valid, bus.axi_readAddr_ready}, 2'b01);
  endtask
  initial begin
    int n;
    vecs[0]  = '{1'b1, 64'h8000_0000, D0,      16'hFFFF, 2'b00};
    vecs[1]  = '{1'b1, 64'h8000_0010, D1,      16'hFFFF, 2'b00};
    vecs[2]  = '{1'b1, 64'h8000_0020, D2,      16'hFFFF, 2'b00};
    vecs[3]  = '{1'b1, 64'h8000_3FF0, DL,      16'hFFFF, 2'b00};
    vecs[4]  = '{1'b0, 64'h8000_0010, D1,      16'h0000, 2'b00};
    vecs[5]  = '{1'b0, 64'h8000_001C, D1,      16'h0000, 2'b00};
    vecs[6]  = '{1'b1, 64'h8000_0000, D5A,     16'h8001, 2'b00};
    vecs[7]  = '{1'b0, 64'h8000_0000, M0,      16'h0000, 2'b00};
    vecs[8]  = '{1'b1, 64'h8000_0000, 128'h0,  16'h0000, 2'b00};
    vecs[9]  = '{1'b0, 64'h8000_0000, M0,      16'h0000, 2'b00};
    vecs[10] = '{1'b0, 64'h7FFF_FFF0, 128'h0,  16'h0000, 2'b10};
    vecs[11] = '{1'b1, 64'h8000_4000, 128'h0,  16'hFFFF, 2'b10};
    vecs[12] = '{1'b0, 64'h8000_0000, M0,      16'h0000, 2'b00};
    vecs[13] = '{1'b0, 64'h8000_3FF0, DL,      16'h0000, 2'b00};
    vecs[14] = '{1'b0, 64'h8000_4000, 128'h0,  16'h0000, 2'b10};
    vecs[15] = '{1'b0, 64'h8000_0020, D2,      16'h0000, 2'b00};
    {bus.axi_readAddr_valid, bus.axi_readData_ready, bus.axi_writeAddr_valid, bus.axi_writeData_valid, bus.axi_writeResp_ready} = '0;
    bus.axi_readAddr_bits_addr = '0; bus.axi_writeAddr_bits_addr = '0;
    bus.axi_readAddr_bits_prot = '0; bus.axi_writeAddr_bits_prot = '0;
    bus.axi_writeData_bits_data = '0; bus.axi_writeData_bits_strb = '0;
    {bus2.axi_readAddr_valid, bus2.axi_readData_ready, bus2.axi_writeAddr_valid, bus2.axi_writeData_valid, bus2.axi_writeResp_ready} = '0;
    bus2.axi_readAddr_bits_addr = '0; bus2.axi_writeAddr_bits_addr = '0;
    bus2.axi_readAddr_bits_prot = '0; bus2.axi_writeAddr_bits_prot = '0;
    bus2.axi_writeData_bits_data = '0; bus2.axi_writeData_bits_strb = '0;
    repeat (3) step();
    rst = 1'b0;
    chk("reset readies", {bus.axi_readAddr_ready, bus.axi_writeAddr_ready, bus.axi_writeData_ready}, 3'b111);
    chk("reset valids/resps", {bus.axi_readData_valid, bus.axi_writeResp_valid, bus.axi_readData_bits_resp, bus.axi_writeResp_bits}, 6'b0);
    chk("reset rdata", bus.axi_readData_bits_data, 128'h0);
    for (int i = 0; i < 16; i++)
      if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].resp);
      else do_read(vecs[i].addr, vecs[i].data, vecs[i].resp);
    // AW first, W four cycles later
    bus.axi_writeAddr_valid = 1'b1;
    bus.axi_writeAddr_bits_addr = 64'h8000_0020;
    step();
    bus.axi_writeAddr_valid = 1'b0;
    chk("aw captured alone", {bus.axi_writeAddr_ready, bus.axi_writeData_ready}, 2'b01);
    repeat (3) step();
    chk("no bvalid before W", bus.axi_writeResp_valid, 1'b0);
    bus.axi_writeData_valid = 1'b1;
    bus.axi_writeData_bits_data = 128'h00FFEEDD;
    bus.axi_writeData_bits_strb = 16'h0003;
    step();
    bus.axi_writeData_valid = 1'b0;
    chk("wready after W", bus.axi_writeData_ready, 1'b0);
    n = 0;
    while (!bus.axi_writeResp_valid && n < 20) begin step(); n++; end
    chk("split write latency", n, 3);
    chk("split bresp", bus.axi_writeResp_bits, 2'b00);
    bus.axi_writeResp_ready = 1'b1;
    step();
    bus.axi_writeResp_ready = 1'b0;
    do_read(64'h8000_0020, 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5EEDD, 2'b00);
    // Concurrent read and write with both responses stalled
    bus.axi_readAddr_valid = 1'b1;
    bus.axi_readAddr_bits_addr = 64'h8000_0010;
    bus.axi_writeAddr_valid = 1'b1;
    bus.axi_writeAddr_bits_addr = 64'h8000_0030;
    bus.axi_writeData_valid = 1'b1;
    bus.axi_writeData_bits_data = D3;
    bus.axi_writeData_bits_strb = 16'hFFFF;
    step();
    {bus.axi_readAddr_valid, bus.axi_writeAddr_valid, bus.axi_writeData_valid} = '0;
    n = 0;
    while (!(bus.axi_readData_valid && bus.axi_writeResp_valid) && n < 20) begin step(); n++; end
    chk("concurrent latency", n, 3);
    for (int i = 0; i < 10; i++) begin
      chk("stall flags", {bus.axi_readData_valid, bus.axi_writeResp_valid, bus.axi_readAddr_ready,
        bus.axi_writeAddr_ready, bus.axi_writeData_ready, bus.axi_readData_bits_resp, bus.axi_writeResp_bits}, 9'b110000000);
      chk("stall rdata", bus.axi_readData_bits_data, D1);
      step();
    end
    bus.axi_readData_ready = 1'b1;
    bus.axi_writeResp_ready = 1'b1;
    step();
    bus.axi_readData_ready = 1'b0;
    bus.axi_writeResp_ready = 1'b0;
    chk("stall release", {bus.axi_readData_valid, bus.axi_writeResp_valid, bus.axi_readAddr_ready,
      bus.axi_writeAddr_ready, bus.axi_writeData_ready}, 5'b00111);
    do_read(64'h8000_0030, D3, 2'b00);
    // Reset lands on the commit edge of a write
    bus.axi_writeAddr_valid = 1'b1;
    bus.axi_writeAddr_bits_addr = 64'h8000_0030;
    bus.axi_writeData_valid = 1'b1;
    bus.axi_writeData_bits_data = DC;
    bus.axi_writeData_bits_strb = 16'hFFFF;
    step();
    bus.axi_writeAddr_valid = 1'b0;
    bus.axi_writeData_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("post-reset write side", {bus.axi_writeResp_valid, bus.axi_writeAddr_ready, bus.axi_writeData_ready}, 3'b011);
    repeat (5) step();
    chk("dropped write no bvalid", bus.axi_writeResp_valid, 1'b0);
    do_read(64'h8000_0030, D3, 2'b00);
    // Latency-2 instance: same-edge commit and read capture on one word
    bus2.axi_writeAddr_valid = 1'b1;
    bus2.axi_writeAddr_bits_addr = 64'h8000_0050;
    bus2.axi_writeData_valid = 1'b1;
    bus2.axi_writeData_bits_data = DB;
    bus2.axi_writeData_bits_strb = 16'hFFFF;
    step();
    bus2.axi_writeAddr_valid = 1'b0;
    bus2.axi_writeData_valid = 1'b0;
    n = 0;
    while (!bus2.axi_writeResp_valid && n < 20) begin step(); n++; end
    chk("lat2 write latency", n, 2);
    bus2.axi_writeResp_ready = 1'b1;
    step();
    bus2.axi_writeResp_ready = 1'b0;
    bus2.axi_readAddr_valid = 1'b1;
    bus2.axi_readAddr_bits_addr = 64'h8000_0050;
    bus2.axi_writeAddr_valid = 1'b1;
    bus2.axi_writeData_valid = 1'b1;
    bus2.axi_writeData_bits_data = DC;
    bus2.axi_writeData_bits_strb = 16'h00FF;
    step();
    {bus2.axi_readAddr_valid, bus2.axi_writeAddr_valid, bus2.axi_writeData_valid} = '0;
    n = 0;
    while (!bus2.axi_readData_valid && n < 20) begin step(); n++; end
    chk("lat2 read latency", n, 2);
    chk("lat2 bvalid with rvalid", bus2.axi_writeResp_valid, 1'b1);
    chk("lat2 merged read", bus2.axi_readData_bits_data, 128'h11111111_11111111_22222222_22222222);
    bus2.axi_readData_ready = 1'b1;
    bus2.axi_writeResp_ready = 1'b1;
    step();
    bus2.axi_readData_ready = 1'b0;
    bus2.axi_writeResp_ready = 1'b0;
    chk("lat2 release", {bus2.axi_readData_valid, bus2.axi_writeResp_valid}, 2'b00);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
